debounced_io_ctrl: RTL and testbench

Parametrised front-panel controller for the Arty A7 buttons, switches and LEDs. Each channel synchronises and debounces its button and produces a one-cycle press pulse. A per-channel switch selects momentary or toggle drive of the green LED. Each press steps that channel's RGB LED through a colour sequence at PWM-dimmed brightness. It sits directly under the board top wrapper, on the internal clock from the clocking wizard.

---
 rtl/debounced_io_ctrl_pkg.sv | 32 +++
 rtl/debounced_io_ctrl_debouncer.sv | 57 +++++
 rtl/debounced_io_ctrl.sv | 91 +++++++++
 tb/tb_debounced_io_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounced_io_ctrl_pkg.sv
// Shared types for the front-panel controller: RGB LED drive, colour sequence
// states and the colour-to-pin mapping.
package debounced_io_ctrl_pkg;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_led_t;

  typedef enum logic [2:0] {
    OFF   = 3'd0,
    RED   = 3'd1,
    GREEN = 3'd2,
    BLUE  = 3'd3,
    WHITE = 3'd4
  } colour_t;

  function automatic rgb_led_t colour_to_rgb(input colour_t c);
    rgb_led_t rgb;
    case (c)
      OFF:     rgb = rgb_led_t'(3'b000);
      RED:     rgb = rgb_led_t'(3'b100);
      GREEN:   rgb = rgb_led_t'(3'b010);
      BLUE:    rgb = rgb_led_t'(3'b001);
      WHITE:   rgb = rgb_led_t'(3'b111);
      default: rgb = rgb_led_t'(3'b000);
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/debounced_io_ctrl_debouncer.sv
// Per-button 2-flop synchroniser and debouncer: a level change is accepted only
// after DEBOUNCE_CYCLES consecutive cycles of disagreement with the stable level.
module debouncer
  import debounced_io_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_dly_q;
  logic          stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Any sample agreeing with the stable level restarts the count.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = ~stable_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Synchroniser, debounce state and one-cycle-delayed level for edge detect.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= raw_i;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
    end
  end

  assign level_o = stable_q;
  assign press_o = stable_q & ~stable_dly_q;

endmodule

// File: rtl/debounced_io_ctrl.sv
// Front-panel controller: debounced buttons, momentary/toggle green LEDs and
// press-stepped RGB colour sequence dimmed by a shared PWM counter.
module debounced_io_ctrl
  import debounced_io_ctrl_pkg::*;
#(
  parameter int unsigned       NUM_CH          = 4,
  parameter int unsigned       DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned       PWM_BITS        = 8,
  parameter logic [PWM_BITS:0] DUTY            = (PWM_BITS+1)'(32)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [NUM_CH-1:0] buttons,
  input  logic [NUM_CH-1:0] switches,
  output logic [NUM_CH-1:0] green_leds,
  output rgb_led_t          rgb_leds [NUM_CH],
  output logic [NUM_CH-1:0] press_o
);

  logic [NUM_CH-1:0]   level_s, press_s;
  logic [NUM_CH-1:0]   sw_sync1_q, sw_sync2_q;
  logic [NUM_CH-1:0]   tog_q;
  colour_t             colour_q [NUM_CH];
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                on_s;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .raw_i  (buttons[g]),
      .level_o(level_s[g]),
      .press_o(press_s[g])
    );
  end

  // Switch synchronisers, toggle state and free-running PWM counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
      tog_q      <= '0;
      pwm_cnt_q  <= '0;
    end else begin
      sw_sync1_q <= switches;
      sw_sync2_q <= sw_sync1_q;
      tog_q      <= tog_q ^ press_s;
      pwm_cnt_q  <= pwm_cnt_q + PWM_BITS'(1);
    end
  end

  // Colour sequencer: one step per accepted press, each channel independent.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NUM_CH; i++) colour_q[i] <= OFF;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (press_s[i]) begin
          case (colour_q[i])
            OFF:     colour_q[i] <= RED;
            RED:     colour_q[i] <= GREEN;
            GREEN:   colour_q[i] <= BLUE;
            BLUE:    colour_q[i] <= WHITE;
            WHITE:   colour_q[i] <= OFF;
            default: colour_q[i] <= OFF;
          endcase
        end
      end
    end
  end

  // Widening the counter makes DUTY >= 2^PWM_BITS mean always lit.
  assign on_s = ({1'b0, pwm_cnt_q} < DUTY);

  // RGB drive: colour pins gated by the shared PWM on-time.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (on_s) begin
        rgb_leds[i] = colour_to_rgb(colour_q[i]);
      end else begin
        rgb_leds[i] = rgb_led_t'(3'b000);
      end
    end
  end

  assign green_leds = (sw_sync2_q & tog_q) | (~sw_sync2_q & level_s);
  assign press_o    = press_s;

endmodule

// File: tb/tb_debounced_io_ctrl.sv
// Scoreboard bench: a behavioural model predicts presses, LED levels and colours;
// a negedge monitor compares the DUT against it every cycle.
`timescale 1ns/1ps
module tb_debounced_io_ctrl;
  import debounced_io_ctrl_pkg::*;

  localparam int NCH = 4;
  localparam int DB  = 8;
  localparam int PB  = 4;
  localparam logic [PB:0] DUTY_P = 5'd4;

  logic           clk = 1'b0;
  logic           rstn = 1'b1;
  logic [NCH-1:0] buttons = '0;
  logic [NCH-1:0] switches = '0;
  logic [NCH-1:0] green, press;
  rgb_led_t       rgb [NCH];

  always #5 clk = ~clk;

  debounced_io_ctrl #(
    .NUM_CH(NCH), .DEBOUNCE_CYCLES(DB), .PWM_BITS(PB), .DUTY(DUTY_P)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .buttons(buttons), .switches(switches),
    .green_leds(green), .rgb_leds(rgb), .press_o(press)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int press0_cnt = 0;

  typedef struct packed { int c; logic [NCH-1:0] m; } exp_t;
  exp_t exp_q[$];

  // Model state: acc = accepted level in the pin domain, vis = level seen at the outputs.
  logic [NCH-1:0] acc_m, d1_m, vis_m, press_m, tog_m, sws1_m, swvis_m;
  int run_m [NCH];
  int col_m [NCH];
  int pwm_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2:0] col_bits(input int c);
    case (c)
      1:       return 3'b100;
      2:       return 3'b010;
      3:       return 3'b001;
      4:       return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    acc_m = '0; d1_m = '0; vis_m = '0; press_m = '0; tog_m = '0;
    sws1_m = '0; swvis_m = '0; pwm_m = 0;
    for (int i = 0; i < NCH; i++) begin run_m[i] = 0; col_m[i] = 0; end
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [NCH-1:0] rise;
    exp_t e;
    cyc++;
    tog_m = tog_m ^ press_m;
    for (int i = 0; i < NCH; i++) if (press_m[i]) col_m[i] = (col_m[i] + 1) % 5;
    pwm_m   = (pwm_m + 1) % (1 << PB);
    swvis_m = sws1_m;
    sws1_m  = switches;
    press_m = d1_m & ~vis_m;
    vis_m   = d1_m;
    d1_m    = acc_m;
    rise = '0;
    for (int i = 0; i < NCH; i++) begin
      if (buttons[i] != acc_m[i]) begin
        run_m[i]++;
        if (run_m[i] == DB) begin
          acc_m[i] = ~acc_m[i];
          run_m[i] = 0;
          if (acc_m[i]) rise[i] = 1'b1;
        end
      end else begin
        run_m[i] = 0;
      end
    end
    if (rise != '0) begin
      e.c = cyc + 2;
      e.m = rise;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) model_reset();
      else model_step();
    end
  end

  // Monitor: per-cycle LED comparison plus press scoreboard.
  initial begin
    logic [NCH-1:0]   exp_green;
    logic [3*NCH-1:0] act_rgb, exp_rgb;
    forever begin
      @(negedge clk);
      exp_green = (swvis_m & tog_m) | (~swvis_m & vis_m);
      check("green_leds", 32'(green), 32'(exp_green));
      for (int i = 0; i < NCH; i++) begin
        act_rgb[3*i +: 3] = rgb[i];
        exp_rgb[3*i +: 3] = (pwm_m < int'(DUTY_P)) ? col_bits(col_m[i]) : 3'b000;
      end
      check("rgb_leds", 32'(act_rgb), 32'(exp_rgb));
      while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
        check("press_missing", 32'(0), 32'(exp_q[0].m));
        void'(exp_q.pop_front());
      end
      if (press != '0) begin
        if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
          check("press_o", 32'(press), 32'(exp_q[0].m));
          void'(exp_q.pop_front());
        end else begin
          check("press_unexpected", 32'(press), 32'(0));
        end
      end
      if (press[0]) press0_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    step(2);
    rstn = 1'b1;
  endtask

  initial begin
    int p, s, lit;
    logic [2:0] seen;
    logic [2:0] exp_seq [5];
    int hold [NCH];
    exp_seq[0] = 3'b100; exp_seq[1] = 3'b010; exp_seq[2] = 3'b001;
    exp_seq[3] = 3'b111; exp_seq[4] = 3'b000;

    // 1. Reset with random inputs, then quiet idle.
    #1 rstn = 1'b0;
    buttons  = NCH'($urandom);
    switches = NCH'($urandom);
    repeat (3) @(negedge clk);
    check("reset_green", 32'(green), 32'(0));
    check("reset_press", 32'(press), 32'(0));
    buttons = '0; switches = '0;
    @(posedge clk); #2 rstn = 1'b1;
    repeat (50) begin
      @(negedge clk);
      check("idle_outputs", 32'({green, press}), 32'(0));
    end

    // 2. Bounce on channel 0.
    step(1);
    press0_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      buttons[0] = ~buttons[0];
      step(3);
    end
    check("bounce_no_press", 32'(press0_cnt), 32'(0));
    buttons[0] = 1'b1;
    p = cyc;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (green[0]) break;
    end
    check("bounce_latency", 32'(cyc - p), 32'(10));
    step(5);
    check("bounce_one_press", 32'(press0_cnt), 32'(1));
    buttons[0] = 1'b0;
    step(14);

    // 3. Toggle mode on channel 1.
    switches[1] = 1'b1;
    step(3);
    for (int k = 0; k < 2; k++) begin
      buttons[1] = 1'b1; step(14);
      buttons[1] = 1'b0; step(14);
      check("toggle_green", 32'(green[1]), (k == 0) ? 32'(1) : 32'(0));
    end
    buttons[1] = 1'b1; step(14);
    switches[1] = 1'b0;
    step(2);
    check("held_momentary", 32'(green[1]), 32'(1));
    buttons[1] = 1'b0; step(14);
    check("released_momentary", 32'(green[1]), 32'(0));
    switches[1] = 1'b1;
    repeat (2) @(negedge clk);
    check("switch_lat_before", 32'(green[1]), 32'(0));
    @(negedge clk);
    check("switch_lat_after", 32'(green[1]), 32'(1));
    step(1);

    // 4. Colour cycle on channel 2.
    for (int k = 0; k < 5; k++) begin
      buttons[2] = 1'b1; step(12);
      buttons[2] = 1'b0; step(12);
      lit = 0; seen = 3'b000;
      for (int t = 0; t < 16; t++) begin
        @(negedge clk);
        if (rgb[2] != 3'b000) lit++;
        seen = seen | rgb[2];
      end
      check("colour_value", 32'(seen), 32'(exp_seq[k]));
      check("colour_duty", 32'(lit), (k == 4) ? 32'(0) : 32'(4));
      step(1);
    end

    // 5. Simultaneous presses after a fresh reset.
    apply_reset();
    buttons = '1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (press != '0) break;
    end
    check("simultaneous_press", 32'(press), 32'({NCH{1'b1}}));
    step(3);
    for (int i = 0; i < NCH; i++) begin
      seen = 3'b000;
      for (int t = 0; t < 16; t++) begin
        @(negedge clk);
        seen = seen | rgb[i];
      end
      check("simultaneous_red", 32'(seen), 32'(3'b100));
    end
    buttons = '0;
    step(14);

    // 6. Asynchronous reset while channel 3 is held.
    buttons[3] = 1'b1;
    step(12);
    check("held_before_reset", 32'(green[3]), 32'(1));
    @(posedge clk); #3 rstn = 1'b0;
    #1;
    check("async_reset_green", 32'(green), 32'(0));
    check("async_reset_press", 32'(press), 32'(0));
    for (int i = 0; i < NCH; i++) check("async_reset_rgb", 32'(rgb[i]), 32'(0));
    @(posedge clk); #2 rstn = 1'b1;
    s = cyc;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (press[3]) break;
    end
    check("repress_latency", 32'(cyc - s), 32'(10));
    buttons = '0;
    step(14);

    // Randomised hold lengths and switch flips, checked by the monitor.
    for (int i = 0; i < NCH; i++) hold[i] = 0;
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < NCH; i++) begin
        if (hold[i] == 0) begin
          buttons[i] = 1'($urandom_range(0, 1));
          hold[i] = $urandom_range(1, 20);
        end else begin
          hold[i]--;
        end
      end
      if ($urandom_range(0, 40) == 0) begin
        s = $urandom_range(0, NCH - 1);
        switches[s] = ~switches[s];
      end
      step(1);
    end
    buttons = '0;
    step(30);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
